vga_pattern_gen: RTL and testbench

// - Pixel stage downstream of the h/v timing counters. Consumes x/y position, active flags and syncs.
// - Produces RGB565 test patterns for the 480x272 LCD, with DE and syncs delayed to stay aligned.
// - Pattern mode advances only at frame boundaries. An 8-bit frame counter animates the SCROLL mode.

---
 rtl/vga_pattern_gen_pkg.sv | 21 ++
 rtl/vga_bar_colour.sv | 19 +
 rtl/vga_pattern_gen.sv | 99 +++++++++
 tb/tb_vga_pattern_gen.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pattern_gen_pkg.sv
// vga_pattern_gen_pkg: mode codes, RGB565 colours and panel geometry defaults
package vga_pattern_gen_pkg;
    localparam int HACTIVE_DEF = 480;
    localparam int VACTIVE_DEF = 272;

    typedef enum logic [1:0] {
        MODE_BARS     = 2'd0,
        MODE_GRID     = 2'd1,
        MODE_GRADIENT = 2'd2,
        MODE_SCROLL   = 2'd3
    } mode_t;

    localparam logic [15:0] WHITE   = 16'hFFFF;
    localparam logic [15:0] YELLOW  = 16'hFFE0;
    localparam logic [15:0] CYAN    = 16'h07FF;
    localparam logic [15:0] GREEN   = 16'h07E0;
    localparam logic [15:0] MAGENTA = 16'hF81F;
    localparam logic [15:0] RED     = 16'hF800;
    localparam logic [15:0] BLUE    = 16'h001F;
    localparam logic [15:0] BLACK   = 16'h0000;
endpackage

// File: rtl/vga_bar_colour.sv
// vga_bar_colour: combinational x -> RGB565 colour bar lookup
module vga_bar_colour
    import vga_pattern_gen_pkg::*;
#(
    parameter int BAR_WIDTH = 60
) (
    input  logic [8:0]  x,
    output logic [15:0] rgb
);
    localparam logic [15:0] PALETTE [8] = '{WHITE, YELLOW, CYAN, GREEN, MAGENTA, RED, BLUE, BLACK};

    logic [2:0] idx;

    always_comb begin
        idx = '0;
        for (int k = 1; k < 8; k++) idx = idx + 3'(int'(x) >= BAR_WIDTH * k);
        rgb = PALETTE[idx];
    end
endmodule

// File: rtl/vga_pattern_gen.sv
// vga_pattern_gen: RGB565 test patterns with DE/syncs aligned at 2 clks latency.
// PATTERN_BORDER_EN adds a white one-pixel border over every mode.
module vga_pattern_gen
    import vga_pattern_gen_pkg::*;
#(
`ifdef PATTERN_BORDER_EN
    parameter int HACTIVE    = HACTIVE_DEF,
    parameter int VACTIVE    = VACTIVE_DEF,
`endif
    parameter int BAR_WIDTH  = 60,
    parameter int GRID_SHIFT = 5
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [8:0] x_i,
    input  logic [8:0] y_i,
    input  logic       hactive_i,
    input  logic       vactive_i,
    input  logic       hsync_i,
    input  logic       vsync_i,
    input  logic       mode_next_i,
    output logic [4:0] r_o,
    output logic [5:0] g_o,
    output logic [4:0] b_o,
    output logic       de_o,
    output logic       hsync_o,
    output logic       vsync_o
);
    logic [8:0]  x1;
    logic [8:0]  y1;
    logic        de1;
    logic        hs1;
    logic        vs1;
    logic        vs_prev;
    logic        pending;
    logic [7:0]  frame_cnt;
    mode_t       mode;
    logic [15:0] bar;
    logic [15:0] rgb;
    logic [4:0]  s;
    logic        fe;

    assign fe = vs_prev & ~vsync_i;
    // bit 4 of the scroll sum depends only on the low five bits of x and frame_cnt
    assign s = x1[4:0] + frame_cnt[4:0];

    vga_bar_colour #(.BAR_WIDTH(BAR_WIDTH)) u_bar (
        .x  (x1),
        .rgb(bar)
    );

    always_comb begin
        rgb = mode == MODE_BARS     ? bar :
              mode == MODE_GRID     ? ((x1[GRID_SHIFT-1:0] == '0 || y1[GRID_SHIFT-1:0] == '0) ? WHITE : BLACK) :
              mode == MODE_GRADIENT ? {x1[8:4], y1[8:3], 5'd31 - x1[8:4]} :
              (((s >= 5'd16) ^ y1[4]) ? WHITE : BLACK);
`ifdef PATTERN_BORDER_EN
        if (x1 == '0 || x1 == 9'(HACTIVE - 1) || y1 == '0 || y1 == 9'(VACTIVE - 1)) rgb = WHITE;
`endif
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            x1        <= '0;
            y1        <= '0;
            de1       <= 1'b0;
            hs1       <= 1'b1;
            vs1       <= 1'b1;
            r_o       <= '0;
            g_o       <= '0;
            b_o       <= '0;
            de_o      <= 1'b0;
            hsync_o   <= 1'b1;
            vsync_o   <= 1'b1;
            mode      <= MODE_BARS;
            frame_cnt <= '0;
            pending   <= 1'b0;
            vs_prev   <= 1'b1;
        end else begin
            x1                <= x_i;
            y1                <= y_i;
            de1               <= hactive_i & vactive_i;
            hs1               <= hsync_i;
            vs1               <= vsync_i;
            {r_o, g_o, b_o}   <= de1 ? rgb : BLACK;
            de_o              <= de1;
            hsync_o           <= hs1;
            vsync_o           <= vs1;
            vs_prev           <= vsync_i;
            if (fe) frame_cnt <= frame_cnt + 8'd1;
            if (fe && (pending || mode_next_i)) begin
                mode    <= mode_t'(mode + 2'd1);
                pending <= 1'b0;
            end else if (mode_next_i) begin
                pending <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_vga_pattern_gen.sv
// tb_vga_pattern_gen: table-driven vectors and mode/scroll sequences checked through an output scoreboard
module tb_vga_pattern_gen;
    logic       clk = 1'b0;
    logic       rst;
    logic [8:0] x;
    logic [8:0] y;
    logic       hact;
    logic       vact;
    logic       hs;
    logic       vs;
    logic       mn;
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
    logic       de_o;
    logic       hs_o;
    logic       vs_o;

    always #5 clk = ~clk;

    vga_pattern_gen dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .x_i        (x),
        .y_i        (y),
        .hactive_i  (hact),
        .vactive_i  (vact),
        .hsync_i    (hs),
        .vsync_i    (vs),
        .mode_next_i(mn),
        .r_o        (r),
        .g_o        (g),
        .b_o        (b),
        .de_o       (de_o),
        .hsync_o    (hs_o),
        .vsync_o    (vs_o)
    );

    localparam logic [15:0] W  = 16'hFFFF;
    localparam logic [15:0] Y  = 16'hFFE0;
    localparam logic [15:0] C  = 16'h07FF;
    localparam logic [15:0] G  = 16'h07E0;
    localparam logic [15:0] M  = 16'hF81F;
    localparam logic [15:0] R  = 16'hF800;
    localparam logic [15:0] B  = 16'h001F;
    localparam logic [15:0] BK = 16'h0000;
`ifdef PATTERN_BORDER_EN
    localparam bit BORDER = 1'b1;
`else
    localparam bit BORDER = 1'b0;
`endif

    typedef struct {
        logic [8:0]  x;
        logic [8:0]  y;
        logic        ha;
        logic        va;
        logic        hs;
        logic        de;
        logic [15:0] rgb;
    } vec_t;

    typedef struct {
        int          id;
        logic [18:0] v;
    } exp_t;

    exp_t  q[$];
    int    n_tests = 0;
    int    n_fail  = 0;
    int    id      = 0;
    int    fc      = 0;
    string phase   = "";

    function automatic logic [18:0] outs();
        return {de_o, hs_o, vs_o, r, g, b};
    endfunction

    task automatic check(input string name, input logic [18:0] got, input logic [18:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got de/hs/vs/rgb=%b/%b/%b/%h want %b/%b/%b/%h",
                     name, got[18], got[17], got[16], got[15:0], want[18], want[17], want[16], want[15:0]);
        end
    endtask

    task automatic step(input logic [8:0] xx, input logic [8:0] yy, input logic ha, input logic va,
                        input logic h, input logic v, input logic m, input logic ed, input logic [15:0] rgb);
        exp_t e;
        x    = xx;
        y    = yy;
        hact = ha;
        vact = va;
        hs   = h;
        vs   = v;
        mn   = m;
        q.push_back('{id, {ed, h, v, rgb}});
        id++;
        @(posedge clk);
        #1;
        if (q.size() == 2) begin
            e = q.pop_front();
            check($sformatf("%s#%0d", phase, e.id), outs(), e.v);
        end
    endtask

    task automatic idle(input logic m);
        step(9'd0, 9'd0, 1'b0, 1'b0, 1'b1, 1'b1, m, 1'b0, BK);
    endtask

    task automatic pix(input logic [8:0] xx, input logic [8:0] yy, input logic [15:0] rgb);
        step(xx, yy, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, rgb);
    endtask

    task automatic fedge(input logic m);
        step(9'd0, 9'd0, 1'b0, 1'b0, 1'b1, 1'b0, m, 1'b0, BK);
        step(9'd0, 9'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, BK);
        fc = (fc + 1) % 256;
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        x    = 9'd200;
        y    = 9'd100;
        hact = 1'b1;
        vact = 1'b1;
        hs   = 1'b0;
        vs   = 1'b0;
        mn   = 1'b1;
        q.delete();
        repeat (3) begin
            @(posedge clk);
            #1;
            check({phase, "_rst"}, outs(), {1'b0, 1'b1, 1'b1, 16'h0000});
        end
        rst = 1'b0;
        fc  = 0;
    endtask

    function automatic logic [15:0] scr(input int xx, input int yy);
        return ((((xx + fc) % 32) >= 16) ^ yy[4]) ? W : BK;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not end, elapsed %0t required < 2000000", $time);
        $fatal(1);
    end

    initial begin
        vec_t tbl[16];
        tbl[0]  = '{9'd0,   9'd5, 1'b0, 1'b0, 1'b1, 1'b0, BK};
        tbl[1]  = '{9'd130, 9'd5, 1'b1, 1'b1, 1'b1, 1'b1, C};
        tbl[2]  = '{9'd130, 9'd5, 1'b0, 1'b1, 1'b1, 1'b0, BK};
        tbl[3]  = '{9'd59,  9'd5, 1'b1, 1'b1, 1'b1, 1'b1, W};
        tbl[4]  = '{9'd60,  9'd5, 1'b1, 1'b1, 1'b1, 1'b1, Y};
        tbl[5]  = '{9'd119, 9'd5, 1'b1, 1'b1, 1'b1, 1'b1, Y};
        tbl[6]  = '{9'd120, 9'd5, 1'b1, 1'b1, 1'b1, 1'b1, C};
        tbl[7]  = '{9'd180, 9'd5, 1'b1, 1'b1, 1'b1, 1'b1, G};
        tbl[8]  = '{9'd240, 9'd5, 1'b1, 1'b1, 1'b1, 1'b1, M};
        tbl[9]  = '{9'd300, 9'd5, 1'b1, 1'b1, 1'b1, 1'b1, R};
        tbl[10] = '{9'd360, 9'd5, 1'b1, 1'b1, 1'b1, 1'b1, B};
        tbl[11] = '{9'd419, 9'd5, 1'b1, 1'b1, 1'b1, 1'b1, B};
        tbl[12] = '{9'd420, 9'd5, 1'b1, 1'b1, 1'b1, 1'b1, BK};
        tbl[13] = '{9'd479, 9'd5, 1'b1, 1'b1, 1'b1, 1'b1, BORDER ? W : BK};
        tbl[14] = '{9'd200, 9'd5, 1'b1, 1'b0, 1'b0, 1'b0, BK};
        tbl[15] = '{9'd1,   9'd5, 1'b1, 1'b1, 1'b0, 1'b1, W};

        phase = "init";
        do_reset();

        phase = "bars";
        for (int i = 0; i < 16; i++)
            step(tbl[i].x, tbl[i].y, tbl[i].ha, tbl[i].va, tbl[i].hs, 1'b1, 1'b0, tbl[i].de, tbl[i].rgb);

        // two requests in one frame must yield a single advance
        phase = "req2";
        idle(1'b1);
        idle(1'b0);
        idle(1'b1);
        pix(9'd1, 9'd1, W);
        pix(9'd70, 9'd3, Y);
        fedge(1'b0);
        phase = "grid";
        pix(9'd1, 9'd1, BK);
        pix(9'd32, 9'd3, W);
        pix(9'd33, 9'd33, BK);
        pix(9'd1, 9'd0, W);
        pix(9'd479, 9'd100, BORDER ? W : BK);
        pix(9'd40, 9'd64, W);

        // request coincident with the vsync fall is taken at that edge
        phase = "coinc";
        fedge(1'b1);
        pix(9'd32, 9'd8, {5'd2, 6'd1, 5'd29});
        pix(9'd200, 9'd100, {5'd12, 6'd12, 5'd19});
        fedge(1'b0);
        pix(9'd200, 9'd100, {5'd12, 6'd12, 5'd19});

        phase = "scroll4";
        idle(1'b1);
        fedge(1'b0);
        pix(9'd12, 9'd2, scr(12, 2));
        pix(9'd12, 9'd17, scr(12, 17));
        pix(9'd11, 9'd2, scr(11, 2));

        // reset mid-frame with a request pending
        phase = "midrst";
        idle(1'b1);
        do_reset();
        phase = "post";
        pix(9'd1, 9'd1, W);
        fedge(1'b0);
        pix(9'd1, 9'd1, W);

        phase = "scroll";
        repeat (3) begin
            idle(1'b1);
            fedge(1'b0);
        end
        pix(9'd12, 9'd2, W);
        repeat (16) fedge(1'b0);
        pix(9'd12, 9'd2, BK);
        while (fc != 255) fedge(1'b0);
        phase = "wrap";
        pix(9'd16, 9'd2, BK);
        pix(9'd17, 9'd2, W);
        fedge(1'b0);
        pix(9'd16, 9'd2, W);
        pix(9'd15, 9'd2, BK);
        pix(9'd16, 9'd17, BK);
        idle(1'b0);
        idle(1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
